// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
// Provides the FSM and owner encodings, default widths, and the small
// combinational helpers used for winner selection and starvation counting.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W       = 64;
    localparam int DEF_DATA_W       = 64;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int CNT_W            = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_L = 1'b1
    } owner_e;

    // Core has fixed priority unless the loader has been passed over
    // STARVE_LIMIT times in a row.
    function automatic owner_e pick_owner(input logic cpu_req_v,
                                          input logic ld_req_v,
                                          input logic starved_v);
        owner_e own_v;
        if (cpu_req_v && ld_req_v) begin
            own_v = starved_v ? OWN_L : OWN_C;
        end else if (ld_req_v) begin
            own_v = OWN_L;
        end else begin
            own_v = OWN_C;
        end
        return own_v;
    endfunction

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt_v,
                                                 input logic [CNT_W-1:0] limit_v);
        logic [CNT_W-1:0] res_v;
        if (cnt_v >= limit_v) begin
            res_v = limit_v;
        end else begin
            res_v = cnt_v + 4'd1;
        end
        return res_v;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the core (port C) and the
// loader/debug engine (port L).
//
// Ports:
//   clock, reset                      rising-edge clock, async active-low reset
//   cpu_req/we/addr/wdata             core command inputs
//   cpu_gnt, cpu_rvalid, cpu_rdata    core grant, read-valid pulse, read data
//   cpu_stall                         cpu_req & ~cpu_gnt (combinational)
//   ld_*                              same set for the loader port
//   mem_write, mem_read, mem_addr,
//   mem_wdata                         memory command, zero outside ACCESS
//   mem_rdata                         combinational read data from memory
//
// Each grant takes two cycles: IDLE picks a winner and latches its command,
// ACCESS drives the memory and captures read data at its closing edge.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] STARVE_LIM_C = CNT_W'(STARVE_LIMIT);

    state_e              state_r,      state_s;
    owner_e              owner_r,      owner_s;
    logic                we_r,         we_s;
    logic [ADDR_W-1:0]   addr_r,       addr_s;
    logic [DATA_W-1:0]   wdata_r,      wdata_s;
    logic [CNT_W-1:0]    starve_cnt_r, starve_cnt_s;
    logic                cpu_rvalid_r, cpu_rvalid_s;
    logic                ld_rvalid_r,  ld_rvalid_s;
    logic [DATA_W-1:0]   cpu_rdata_r,  cpu_rdata_s;
    logic [DATA_W-1:0]   ld_rdata_r,   ld_rdata_s;

    // State register: FSM state, latched command, starvation count, read returns.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            owner_r      <= OWN_C;
            we_r         <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            starve_cnt_r <= 4'd0;
            cpu_rvalid_r <= 1'b0;
            ld_rvalid_r  <= 1'b0;
            cpu_rdata_r  <= {DATA_W{1'b0}};
            ld_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            we_r         <= we_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            starve_cnt_r <= starve_cnt_s;
            cpu_rvalid_r <= cpu_rvalid_s;
            ld_rvalid_r  <= ld_rvalid_s;
            cpu_rdata_r  <= cpu_rdata_s;
            ld_rdata_r   <= ld_rdata_s;
        end
    end

    // Next-state logic: arbitration and command latch in IDLE, read capture in ACCESS.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        we_s         = we_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        starve_cnt_s = starve_cnt_r;
        cpu_rvalid_s = 1'b0;
        ld_rvalid_s  = 1'b0;
        cpu_rdata_s  = cpu_rdata_r;
        ld_rdata_s   = ld_rdata_r;
        case (state_r)
            IDLE: begin
                if (cpu_req || ld_req) begin
                    state_s = ACCESS;
                    owner_s = pick_owner(cpu_req, ld_req, starve_cnt_r == STARVE_LIM_C);
                    if (owner_s == OWN_L) begin
                        we_s         = ld_we;
                        addr_s       = ld_addr;
                        wdata_s      = ld_wdata;
                        starve_cnt_s = 4'd0;
                    end else begin
                        we_s    = cpu_we;
                        addr_s  = cpu_addr;
                        wdata_s = cpu_wdata;
                        // Only a pending loader request counts as being passed over.
                        if (ld_req) begin
                            starve_cnt_s = sat_inc(starve_cnt_r, STARVE_LIM_C);
                        end else begin
                            starve_cnt_s = 4'd0;
                        end
                    end
                end else begin
                    starve_cnt_s = 4'd0;
                end
            end
            ACCESS: begin
                state_s = IDLE;
                if (!we_r) begin
                    if (owner_r == OWN_L) begin
                        ld_rdata_s  = mem_rdata;
                        ld_rvalid_s = 1'b1;
                    end else begin
                        cpu_rdata_s  = mem_rdata;
                        cpu_rvalid_s = 1'b1;
                    end
                end else begin
                    cpu_rvalid_s = 1'b0;
                    ld_rvalid_s  = 1'b0;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output logic: memory strobes and grants exist only in ACCESS, so an
    // asynchronous reset of state_r removes them without a clock edge.
    always_comb begin
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        cpu_gnt   = 1'b0;
        ld_gnt    = 1'b0;
        if (state_r == ACCESS) begin
            mem_write = we_r;
            mem_read  = ~we_r;
            mem_addr  = addr_r;
            mem_wdata = wdata_r;
            cpu_gnt   = (owner_r == OWN_C);
            ld_gnt    = (owner_r == OWN_L);
        end else begin
            cpu_gnt = 1'b0;
            ld_gnt  = 1'b0;
        end
        cpu_stall = cpu_req & ~cpu_gnt;
    end

    assign cpu_rvalid = cpu_rvalid_r;
    assign ld_rvalid  = ld_rvalid_r;
    assign cpu_rdata  = cpu_rdata_r;
    assign ld_rdata   = ld_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural memory.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ld_req, ld_we, ld_gnt, ld_rvalid;
    logic [63:0] ld_addr, ld_wdata, ld_rdata;
    logic        mem_write, mem_read;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    logic [63:0] mem [0:63];

    int n_pass;
    int n_total;

    dmem_arbiter #(
        .ADDR_W(64),
        .DATA_W(64),
        .STARVE_LIMIT(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_gnt     (ld_gnt),
        .ld_rvalid  (ld_rvalid),
        .ld_rdata   (ld_rdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: combinational read, write on the edge that ends ACCESS.
    assign mem_rdata = mem[mem_addr[5:0]];
    always @(posedge clock) begin
        if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One complete access on a single port, starting in an IDLE cycle and
    // ending in the following IDLE (rvalid) cycle.
    task automatic access(input logic is_ld, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] exp_rdata);
        if (is_ld) begin
            ld_req = 1'b1; ld_we = we; ld_addr = addr; ld_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        tick();
        chk1("gnt_owner", is_ld ? ld_gnt : cpu_gnt, 1'b1);
        chk1("gnt_other", is_ld ? cpu_gnt : ld_gnt, 1'b0);
        chk1("mem_write", mem_write, we);
        chk1("mem_read", mem_read, ~we);
        chk64("mem_addr", mem_addr, addr);
        if (we) chk64("mem_wdata", mem_wdata, wdata);
        cpu_req = 1'b0;
        ld_req  = 1'b0;
        tick();
        chk1("rvalid_owner", is_ld ? ld_rvalid : cpu_rvalid, ~we);
        chk1("rvalid_other", is_ld ? cpu_rvalid : ld_rvalid, 1'b0);
        if (!we) chk64("rdata", is_ld ? ld_rdata : cpu_rdata, exp_rdata);
        chk1("mem_idle", mem_read | mem_write, 1'b0);
    endtask

    logic [9:0] order_c;

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 64'd0; cpu_wdata = 64'd0;
        ld_req = 1'b0;  ld_we = 1'b0;  ld_addr = 64'd0;  ld_wdata = 64'd0;

        // Reset state; stall follows cpu_req while held in reset.
        tick(); tick();
        cpu_req = 1'b1;
        #1;
        chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
        chk1("rst_ld_gnt", ld_gnt, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk64("rst_cpu_rdata", cpu_rdata, 64'd0);
        chk1("rst_cpu_stall", cpu_stall, 1'b1);
        cpu_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Core write then read of 0x10.
        chk1("idle_stall", cpu_stall, 1'b0);
        access(1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF, 64'd0);
        access(1'b0, 1'b0, 64'h10, 64'd0, 64'hDEAD_BEEF);
        chk1("no_ld_rvalid", ld_rvalid, 1'b0);

        // Loader writes 1..8 to 0..7, one grant every two cycles.
        for (int i = 0; i < 8; i++) begin
            access(1'b1, 1'b1, 64'(i), 64'(i + 1), 64'd0);
        end
        access(1'b0, 1'b0, 64'd5, 64'd0, 64'd6);

        // Starvation: both requests held continuously.
        order_c = 10'b0111101111; // bit g = 1 means C expected for grant g
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h20;
        ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 64'h21;
        for (int g = 0; g < 10; g++) begin
            tick();
            chk1("starve_cpu_gnt", cpu_gnt, order_c[g]);
            chk1("starve_ld_gnt", ld_gnt, ~order_c[g]);
            chk1("starve_stall", cpu_stall, ~order_c[g]);
            if (g == 9) begin
                cpu_req = 1'b0;
                ld_req  = 1'b0;
            end
            tick();
            chk1("starve_cpu_rvalid", cpu_rvalid, order_c[g]);
            chk1("starve_ld_rvalid", ld_rvalid, ~order_c[g]);
        end

        // Simultaneous single requests with counter at 0.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h30; cpu_wdata = 64'h77;
        ld_req  = 1'b1; ld_we  = 1'b1; ld_addr  = 64'h31; ld_wdata  = 64'h88;
        tick();
        chk1("sim_cpu_gnt", cpu_gnt, 1'b1);
        chk1("sim_ld_gnt0", ld_gnt, 1'b0);
        chk1("sim_cpu_stall", cpu_stall, 1'b0);
        cpu_req = 1'b0;
        tick();
        chk1("sim_ld_gnt1", ld_gnt, 1'b0);
        tick();
        chk1("sim_ld_gnt2", ld_gnt, 1'b1);
        chk64("sim_ld_addr", mem_addr, 64'h31);
        ld_req = 1'b0;
        tick();

        // Reset in the middle of a loader write of 0xFF to address 3.
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 64'd3; ld_wdata = 64'hFF;
        tick();
        chk1("midw_mem_write", mem_write, 1'b1);
        #2;
        reset = 1'b0;
        ld_req = 1'b0;
        #1;
        chk1("midw_write_drop", mem_write, 1'b0);
        chk1("midw_ld_gnt", ld_gnt, 1'b0);
        chk64("midw_mem_addr", mem_addr, 64'd0);
        chk64("midw_cpu_rdata", cpu_rdata, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        access(1'b1, 1'b0, 64'd3, 64'd0, 64'd4);

        // Read isolation: L read of 5 then C read of 2 back to back.
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 64'd5;
        tick();
        chk1("iso_ld_gnt", ld_gnt, 1'b1);
        ld_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'd2;
        tick();
        chk1("iso_ld_rvalid", ld_rvalid, 1'b1);
        chk64("iso_ld_rdata", ld_rdata, 64'd6);
        chk1("iso_cpu_rvalid0", cpu_rvalid, 1'b0);
        chk64("iso_cpu_rdata_hold", cpu_rdata, 64'd0);
        tick();
        chk1("iso_cpu_gnt", cpu_gnt, 1'b1);
        cpu_req = 1'b0;
        tick();
        chk1("iso_cpu_rvalid", cpu_rvalid, 1'b1);
        chk64("iso_cpu_rdata", cpu_rdata, 64'd3);
        chk1("iso_ld_rvalid0", ld_rvalid, 1'b0);
        chk64("iso_ld_rdata_hold", ld_rdata, 64'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data memory arbiter sharing the `DATA_MEM` port between the `ARM_RISC` core (port C) and a program/data loader or debug engine (port L). It sequences one access per grant through a two-state FSM, gives the core fixed priority, and bounds loader starvation with a saturating counter. It sits between both requesters and `DATA_MEM` and drives `MEM_WRITE`, `MEM_READ`, `MEM_ADDR_IN` and `WRITE_DATA` exclusively.

## Interface
- `ADDR_W`, 64, address width (matches `MEM_ADDR_IN`).
- `DATA_W`, 64, data width (matches `WRITE_DATA` and `DATA_OUT`).
- `STARVE_LIMIT`, 4, maximum consecutive core grants while `ld_req` is pending; legal range 1..15.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`, `cpu_we`  in  1  core request; write when `cpu_we`=1.
- `cpu_addr`  in  ADDR_W; `cpu_wdata`  in  DATA_W.
- `cpu_gnt`  out  1  access performed this cycle.
- `cpu_rvalid`  out  1  read data valid; `cpu_rdata`  out  DATA_W.
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`, combinational.
- `ld_req`, `ld_we`, `ld_addr`, `ld_wdata`, `ld_gnt`, `ld_rvalid`, `ld_rdata`  same meanings and widths as the core port.
- `mem_write`, `mem_read`  out  1; `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W.
- `mem_rdata`  in  DATA_W  `DATA_OUT` from memory; combinational read.

## Operation
- FSM states: IDLE and ACCESS. Registered fields: owner (C/L), we, addr, wdata, starve_cnt (4 bits).
- IDLE: if any request is present, pick a winner, latch its command, and go to ACCESS. Otherwise stay in IDLE.
- Pick rule:
  - Only `cpu_req`: C.
  - Only `ld_req`: L.
  - Both: L if starve_cnt == STARVE_LIMIT, else C.
- ACCESS:
  - Drive `mem_*` from the latched command. `mem_read` = ~we and `mem_write` = we.
  - Assert `gnt` of the owner only.
  - Next state is always IDLE.
- Reads: capture `mem_rdata` at the end of ACCESS into that port's `rdata`. Pulse that port's `rvalid` for one cycle in the following IDLE cycle. `rdata` holds until the next read for that port.
- Writes: no `rvalid`. Memory updates at the edge that ends ACCESS.
- Requester contract:
  - Hold req, we, addr and wdata stable until `gnt` is sampled high.
  - Drop or change the request after that edge.
  - The arbiter ignores the requester's inputs during ACCESS.
- starve_cnt:
  - +1 on a C pick while `ld_req`=1, saturating at STARVE_LIMIT.
  - Cleared on an L pick.
  - Cleared in IDLE when `ld_req`=0.
- `mem_*` are all zero whenever the state is not ACCESS.

## Timing
- Reset (asynchronous, immediate):
  - State → IDLE, starve_cnt → 0.
  - All `gnt`, `rvalid`, `rdata` and `mem_*` outputs → 0.
  - `cpu_stall` follows `cpu_req`.
  - An in-flight access is abandoned; `mem_write` deasserts without waiting for a clock edge.
- Latency:
  - Request sampled at edge N → `gnt` and memory strobes during cycle N+1.
  - Read data and `rvalid` in cycle N+2.
- Throughput: one access per 2 cycles. Arbitration in the `rvalid` cycle permits back-to-back accesses.
- Simultaneous requests at STARVE_LIMIT: L wins, and C sees `cpu_stall`=1 for 2 additional cycles.
- `cpu_gnt` and `ld_gnt` are never high together. The `rvalid` signals are never high together.
- Requests arriving during ACCESS are arbitrated at the edge that returns to IDLE.

## Structure
- Shared package `dmem_arb_pkg`:
  - state enum {IDLE, ACCESS}.
  - owner enum {OWN_C, OWN_L}.
  - Default widths ADDR_W and DATA_W.
- No sub-module. Pick logic, starvation counter and FSM are a single always_ff block plus combinational outputs, about 150–200 lines.

## Test plan
- Core read alone: write 0xDEAD_BEEF to address 0x10 via port C, then read 0x10. Expected: `cpu_gnt` in cycle 1 after the request; `cpu_rvalid`=1 and `cpu_rdata`=0xDEAD_BEEF two cycles after the read request; no `ld_*` activity.
- Loader-only writes: loader writes 0x1..0x8 to addresses 0..7, then the core reads address 5. Expected: one `ld_gnt` every 2 cycles; `cpu_rdata`=0x6.
- Starvation with STARVE_LIMIT=4: hold both `cpu_req` and `ld_req` continuously with reads. Expected grant order is C,C,C,C,L,C,C,C,C,L; no `gnt` overlap.
- Simultaneous single requests with counter 0: expected C is granted first and L is granted 2 cycles later; `cpu_stall`=0 and `ld_gnt` asserted 2 cycles after `cpu_gnt`.
- Reset mid-write: assert `reset`=0 during ACCESS of a port-L write of 0xFF to address 3. Expected: `mem_write` drops immediately, all outputs go to 0, and a subsequent read of address 3 returns the pre-write value.
- Read isolation: port-L read immediately followed by a port-C read of different addresses. Expected: each `rdata` updates only on its own `rvalid`, and `ld_rdata` holds after the C access.
